// File: rtl/elbeth_id_exs_register.sv
// ID->EXS pipeline register.
// Forwards the EXS result into the operands of the instruction leaving ID,
// holds every EXS field while EXS is busy, and replaces the ID instruction
// with a bubble when a taken branch/jump flushes it. A flush that arrives
// during a stall is remembered (HOLD_FL) until the stall releases.
// Two saturating perf counters track forwarded loads and stall cycles.
//
// Handshake: there is no valid/ready pair here. exs_stall acts as an
// inverted "ready" from EXS: an ID instruction (id_valid=1) is transferred
// on a rising edge only when exs_stall=0 and no flush is present. id_stall
// mirrors exs_stall combinationally so ID/IF hold their outputs on exactly
// the cycles in which no transfer happens.
module elbeth_id_exs_register #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_use_imm,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_w_gpr_en,
  input  logic             id_mem_rd,
  input  logic             id_mem_wr,
  input  logic [OP_W-1:0]  id_alu_op,
  input  logic             match_forward_rs1,
  input  logic             match_forward_rs2,
  input  logic [XLEN-1:0]  exs_result,
  input  logic             exs_stall,
  input  logic             flush,
  input  logic             perf_clr,
  output logic             id_stall,
  output logic             exs_valid,
  output logic [XLEN-1:0]  exs_pc,
  output logic [4:0]       exs_rd_addr,
  output logic             exs_w_gpr_en,
  output logic             exs_mem_rd,
  output logic             exs_mem_wr,
  output logic [OP_W-1:0]  exs_alu_op,
  output logic [XLEN-1:0]  exs_op_a,
  output logic [XLEN-1:0]  exs_op_b,
  output logic [XLEN-1:0]  exs_store_data,
  output logic [CNT_W-1:0] perf_fwd_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    HOLD_FL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state_q;
  state_t          state_d;
  logic            do_load;
  logic            do_bubble;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic            fwd_hit;
  logic            fwd_inc;

  // Operand forwarding; a match is only meaningful for a valid ID instruction.
  assign fwd_a   = (match_forward_rs1 && id_valid) ? exs_result : id_rs1_data;
  assign fwd_b   = (match_forward_rs2 && id_valid) ? exs_result : id_rs2_data;
  assign fwd_hit = id_valid && (match_forward_rs1 || match_forward_rs2);
  assign fwd_inc = do_load && fwd_hit;

  assign id_stall  = exs_stall;
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and load/bubble decision; flush always wins over a load.
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_bubble = 1'b0;
    case (state_q)
      RUN, HOLD: begin
        if (exs_stall) begin
          state_d = flush ? HOLD_FL : HOLD;
        end else begin
          state_d = RUN;
          if (flush) begin
            do_bubble = 1'b1;
          end else begin
            do_load = 1'b1;
          end
        end
      end
      HOLD_FL: begin
        if (!exs_stall) begin
          state_d   = RUN;
          do_bubble = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control fields: loaded from ID, cleared for a bubble, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exs_valid    <= 1'b0;
      exs_w_gpr_en <= 1'b0;
      exs_mem_rd   <= 1'b0;
      exs_mem_wr   <= 1'b0;
    end else if (do_bubble) begin
      exs_valid    <= 1'b0;
      exs_w_gpr_en <= 1'b0;
      exs_mem_rd   <= 1'b0;
      exs_mem_wr   <= 1'b0;
    end else if (do_load) begin
      exs_valid    <= id_valid;
      exs_w_gpr_en <= id_w_gpr_en && id_valid;
      exs_mem_rd   <= id_mem_rd;
      exs_mem_wr   <= id_mem_wr;
    end
  end

  // Datapath fields: only a real load updates them; bubbles leave them as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exs_pc         <= '0;
      exs_rd_addr    <= '0;
      exs_alu_op     <= '0;
      exs_op_a       <= '0;
      exs_op_b       <= '0;
      exs_store_data <= '0;
    end else if (do_load) begin
      exs_pc         <= id_pc;
      exs_rd_addr    <= id_rd_addr;
      exs_alu_op     <= id_alu_op;
      exs_op_a       <= fwd_a;
      exs_op_b       <= id_use_imm ? id_imm : fwd_b;
      exs_store_data <= fwd_b;
    end
  end

  // Forwarded-load counter: clear beats increment, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fwd_cnt <= '0;
    end else if (perf_clr) begin
      perf_fwd_cnt <= '0;
    end else if (fwd_inc && (perf_fwd_cnt != CNT_MAX)) begin
      perf_fwd_cnt <= perf_fwd_cnt + CNT_ONE;
    end
  end

  // Stall-cycle counter: clear beats increment, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_stall_cnt <= '0;
    end else if (id_stall && (perf_stall_cnt != CNT_MAX)) begin
      perf_stall_cnt <= perf_stall_cnt + CNT_ONE;
    end
  end

endmodule
